// File: rtl/control_unit.sv
// Control unit FSM for a simple accumulator machine: fetch, decode and execute of eight opcodes.
// Optional single-step mode is enabled with the CU_STEP_EN macro (adds the Step input).
module control_unit (
`ifdef CU_STEP_EN
    input  logic       Step,
`endif
    input  logic       Clock,
    input  logic       Reset,
    input  logic [2:0] IR,
    input  logic       Aeq0,
    input  logic       Apos,
    input  logic       Enter,
    output logic       IRload,
    output logic       JMPmux,
    output logic       PCload,
    output logic       Meminst,
    output logic       MemWr,
    output logic       Aload,
    output logic       Sub,
    output logic [1:0] Asel,
    output logic       Halt,
    output logic       InWait,
    output logic [3:0] debug_state
);

    typedef enum logic [3:0] {
        START  = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        LOAD   = 4'd3,
        STORE  = 4'd4,
        ADD    = 4'd5,
        SUB    = 4'd6,
        INPUT  = 4'd7,
        JZ     = 4'd8,
        JPOS   = 4'd9,
        HALT   = 4'd10
    } state_t;

    state_t state;

    assign debug_state = state;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= START;
        end else begin
            case (state)
`ifdef CU_STEP_EN
                START:   state <= Step ? FETCH : START;
`else
                START:   state <= FETCH;
`endif
                FETCH:   state <= DECODE;
                // IR is only looked at here; it is don't-care in every other state.
                DECODE: begin
                    case (IR)
                        3'b000:  state <= LOAD;
                        3'b001:  state <= STORE;
                        3'b010:  state <= ADD;
                        3'b011:  state <= SUB;
                        3'b100:  state <= INPUT;
                        3'b101:  state <= JZ;
                        3'b110:  state <= JPOS;
                        default: state <= HALT;
                    endcase
                end
                INPUT:   state <= Enter ? START : INPUT;
                HALT:    state <= HALT;
                default: state <= START;
            endcase
        end
    end

    // Outputs decode the registered state; INPUT/JZ/JPOS fold in live datapath inputs.
    always_comb begin
        IRload  = 1'b0;
        JMPmux  = 1'b0;
        PCload  = 1'b0;
        Meminst = 1'b0;
        MemWr   = 1'b0;
        Aload   = 1'b0;
        Sub     = 1'b0;
        Asel    = 2'b00;
        Halt    = 1'b0;
        InWait  = 1'b0;
        case (state)
            FETCH: begin
                IRload = 1'b1;
                PCload = 1'b1;
            end
            DECODE: Meminst = 1'b1;
            LOAD: begin
                Asel  = 2'b10;
                Aload = 1'b1;
            end
            STORE: begin
                Meminst = 1'b1;
                MemWr   = 1'b1;
            end
            ADD: Aload = 1'b1;
            SUB: begin
                Aload = 1'b1;
                Sub   = 1'b1;
            end
            INPUT: begin
                Asel   = 2'b01;
                Aload  = Enter;
                InWait = ~Enter;
            end
            JZ: begin
                JMPmux = 1'b1;
                PCload = Aeq0;
            end
            JPOS: begin
                JMPmux = 1'b1;
                PCload = Apos;
            end
            HALT: Halt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks each opcode, INPUT wait, jumps, HALT and reset recovery.
module tb_control_unit;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [2:0] IR = 3'b000;
    logic       Aeq0 = 1'b0;
    logic       Apos = 1'b0;
    logic       Enter = 1'b0;
`ifdef CU_STEP_EN
    logic       Step = 1'b1;
`endif
    logic       IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Halt, InWait;
    logic [1:0] Asel;
    logic [3:0] debug_state;

    int n_checks = 0;
    int n_errors = 0;

    control_unit dut (
`ifdef CU_STEP_EN
        .Step(Step),
`endif
        .Clock(Clock), .Reset(Reset), .IR(IR), .Aeq0(Aeq0), .Apos(Apos), .Enter(Enter),
        .IRload(IRload), .JMPmux(JMPmux), .PCload(PCload), .Meminst(Meminst),
        .MemWr(MemWr), .Aload(Aload), .Sub(Sub), .Asel(Asel), .Halt(Halt),
        .InWait(InWait), .debug_state(debug_state)
    );

    always #5 Clock = ~Clock;

    // Output bundle order: IRload JMPmux PCload Meminst MemWr Aload Sub Asel[1:0] Halt InWait
    function automatic logic [10:0] mk(input logic irl, input logic jmp, input logic pcl,
                                       input logic mi, input logic mw, input logic al,
                                       input logic sb, input logic [1:0] as,
                                       input logic h, input logic iw);
        return {irl, jmp, pcl, mi, mw, al, sb, as, h, iw};
    endfunction

    localparam logic [10:0] ZERO   = 11'b0;
    localparam logic [10:0] O_FET  = 11'b101_0000_00_00;
    localparam logic [10:0] O_DEC  = 11'b000_1000_00_00;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [10:0] expv);
        logic [10:0] obs;
        obs = {IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Asel, Halt, InWait};
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    // From START: FETCH (with junk IR), DECODE (real IR), then lands in the execute state.
    task automatic run_instr(input logic [2:0] op, input string tag);
        IR = 3'($urandom_range(0, 7));
        tick();
        check({tag, "_fetch"}, O_FET);
        tick();
        check({tag, "_decode"}, O_DEC);
        IR = op;
        tick();
        IR = 3'($urandom_range(0, 7));
    endtask

    initial begin
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("reset_start", ZERO);

        run_instr(3'b000, "load");
        check("load_exec", mk(0,0,0,0,0,1,0,2'b10,0,0));
        tick();
        check("load_start", ZERO);

        run_instr(3'b001, "store");
        check("store_exec", mk(0,0,0,1,1,0,0,2'b00,0,0));
        tick();
        check("store_start", ZERO);

        run_instr(3'b010, "add");
        check("add_exec", mk(0,0,0,0,0,1,0,2'b00,0,0));
        tick();

        run_instr(3'b011, "sub");
        check("sub_exec", mk(0,0,0,0,0,1,1,2'b00,0,0));
        tick();
        check("sub_start", ZERO);

        Enter = 1'b0;
        run_instr(3'b100, "input");
        check("input_wait1", mk(0,0,0,0,0,0,0,2'b01,0,1));
        tick();
        check("input_wait2", mk(0,0,0,0,0,0,0,2'b01,0,1));
        tick();
        check("input_wait3", mk(0,0,0,0,0,0,0,2'b01,0,1));
        Enter = 1'b1;
        #1;
        check("input_enter", mk(0,0,0,0,0,1,0,2'b01,0,0));
        tick();
        check("input_done", ZERO);

        // Enter stays high into the next INPUT: exactly one Aload cycle.
        run_instr(3'b100, "input_hold");
        check("input_hold_load", mk(0,0,0,0,0,1,0,2'b01,0,0));
        tick();
        check("input_hold_start", ZERO);
        Enter = 1'b0;

        Aeq0 = 1'b1;
        run_instr(3'b101, "jz_taken");
        check("jz_taken", mk(0,1,1,0,0,0,0,2'b00,0,0));
        Aeq0 = 1'b0;
        #1;
        check("jz_flag_live", mk(0,1,0,0,0,0,0,2'b00,0,0));
        tick();

        run_instr(3'b101, "jz_not");
        check("jz_not_taken", mk(0,1,0,0,0,0,0,2'b00,0,0));
        tick();
        check("jz_start", ZERO);

        Apos = 1'b1;
        run_instr(3'b110, "jpos");
        check("jpos_taken", mk(0,1,1,0,0,0,0,2'b00,0,0));
        Apos = 1'b0;
        #1;
        check("jpos_not_taken", mk(0,1,0,0,0,0,0,2'b00,0,0));
        tick();
        check("jpos_start", ZERO);

        run_instr(3'b111, "halt");
        check("halt_enter", mk(0,0,0,0,0,0,0,2'b00,1,0));
        for (int i = 0; i < 10; i++) begin
            IR    = 3'(i);
            Enter = i[0];
            Aeq0  = i[1];
            Apos  = i[2];
            tick();
            check("halt_hold", mk(0,0,0,0,0,0,0,2'b00,1,0));
        end
        Enter = 1'b0;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("halt_reset", ZERO);

        // Reset during INPUT wait wins over Enter on the same edge.
        run_instr(3'b100, "rst_input");
        tick();
        check("rst_input_wait", mk(0,0,0,0,0,0,0,2'b01,0,1));
        Reset = 1'b1;
        Enter = 1'b1;
        tick();
        Reset = 1'b0;
        Enter = 1'b0;
        check("rst_input_start", ZERO);
        tick();
        check("rst_input_fetch", O_FET);

        // Reset from FETCH returns to START.
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("rst_fetch_start", ZERO);

`ifdef CU_STEP_EN
        Step = 1'b0;
        tick();
        check("step_hold1", ZERO);
        tick();
        check("step_hold2", ZERO);
        Step = 1'b1;
        tick();
        Step = 1'b0;
        check("step_fetch", O_FET);
        tick();
        check("step_decode", O_DEC);
`else
        tick();
        check("nostep_fetch", O_FET);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL: Clock  input  1  sole clock; all state changes on rising edge.
REQ-002 SHALL: Reset  input  1  synchronous, active-high; sampled on rising Clock.
REQ-003 SHALL: IR  input  3  opcode from datapath instruction register.
REQ-004 SHALL: Aeq0  input  1  accumulator-equals-zero flag from datapath.
REQ-005 SHALL: Apos  input  1  accumulator-positive flag from datapath.
REQ-006 SHALL: Enter  input  1  operator strobe; data_in valid while high.
REQ-007 SHALL: IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub  output  1 each  datapath control lines.
REQ-008 SHALL: Asel  output  2  accumulator source: 00 adder/subtractor, 01 data_in, 10 RAM out, 11 unused.
REQ-009 SHALL: Halt  output  1  high only in HALT state.
REQ-010 SHALL: InWait  output  1  high in INPUT state while Enter low.

Function
REQ-011 SHALL: implement states START, FETCH, DECODE, LOAD, STORE, ADD, SUB, INPUT, JZ, JPOS, HALT in one registered state variable.
REQ-012 SHALL: drive every output 0 in any state unless listed below for that state.
REQ-013 SHALL: START -> FETCH unconditionally; no outputs asserted.
REQ-014 SHALL: FETCH asserts IRload=1, PCload=1, JMPmux=0; -> DECODE.
REQ-015 SHALL: DECODE asserts Meminst=1; next state by IR: 000 LOAD, 001 STORE, 010 ADD, 011 SUB, 100 INPUT, 101 JZ, 110 JPOS, 111 HALT.
REQ-016 SHALL: LOAD asserts Asel=10, Aload=1; -> START.
REQ-017 SHALL: STORE asserts Meminst=1, MemWr=1; -> START.
REQ-018 SHALL: ADD asserts Asel=00, Aload=1, Sub=0; SUB asserts Asel=00, Aload=1, Sub=1; both -> START.
REQ-019 SHALL: INPUT asserts Asel=01 always, Aload=Enter combinationally; stays in INPUT while Enter=0; -> START on cycle Enter=1.
REQ-020 SHALL: JZ asserts JMPmux=1, PCload=Aeq0 combinationally; JPOS asserts JMPmux=1, PCload=Apos; both -> START regardless of flag.
REQ-021 SHALL: HALT asserts Halt=1, holds until Reset; IR, flags, Enter ignored.
REQ-022 SHALL: IR sampled only in DECODE; changes in other states have no effect.
REQ-023 SHALL: non-INPUT, non-HALT instruction complete in exactly 4 cycles (START, FETCH, DECODE, execute); INPUT takes 4 + wait cycles.
REQ-024 SHALL: Enter held high across multiple INPUT entries load once per INPUT visit (single Aload cycle per instruction).
REQ-025 SHALL: never assert MemWr together with Aload, nor IRload outside FETCH.

Reset
REQ-026 SHALL: Reset=1 at a rising edge force state START on that edge, from any state including INPUT wait and HALT.
REQ-027 SHALL: in the cycle after Reset, all outputs 0 (START outputs); Reset has priority over Step and Enter.

Configuration
REQ-028 SHALL: macro CU_STEP_EN, when defined, add input Step (1 bit) and make START -> FETCH only on a cycle with Step=1, else remain in START.
REQ-029 SHALL: without CU_STEP_EN, no Step port exists and START -> FETCH unconditionally per REQ-013.

Verification
REQ-030 SHALL: Reset 1 cycle, IR=000 -> cycles: START all 0; FETCH IRload=PCload=1; DECODE Meminst=1; LOAD Asel=10 Aload=1; back to START.
REQ-031 SHALL: IR=001 -> execute cycle Meminst=1 MemWr=1, Aload=0; IR=011 -> execute cycle Asel=00 Aload=1 Sub=1.
REQ-032 SHALL: IR=100, Enter low 3 cycles then high -> InWait=1 for 3 INPUT cycles, Aload=0 then Aload=1 Asel=01 once, then START.
REQ-033 SHALL: IR=101 with Aeq0=1 -> JZ cycle JMPmux=1 PCload=1; repeat Aeq0=0 -> PCload=0; IR=110 with Apos=1 -> PCload=1.
REQ-034 SHALL: IR=111 -> Halt=1 held 10 cycles despite IR toggling; Reset pulse -> START, Halt=0 next cycle.
REQ-035 SHALL: Reset asserted during INPUT wait -> START next cycle, InWait=0; with CU_STEP_EN, Step=0 holds START, Step=1 pulse enters FETCH next cycle.
